// File: rtl/alu_seq64.sv
// alu_seq64: runs 2*WIDTH-bit ADD/SUB/AND/XOR/ORR/CMP through an external
// WIDTH-bit ALU in two passes (low word, then high word with carry chaining),
// with a valid/ready request side and a valid/ready response side.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request, ALU drive parked at zero
// LO     | low words on the ALU, carry/zero latched at end of cycle
// HI     | high words on the ALU with chained carry, response latched
// RESP   | response held stable until consumed
module alu_seq64 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic [3:0]           alu_control,
    output logic                 alu_ci,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_co,
    input  logic                 alu_ovf,
    input  logic                 alu_z,
    input  logic                 alu_n,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 rsp_c,
    output logic                 rsp_v,
    output logic                 rsp_z,
    output logic                 rsp_n,
    output logic                 rsp_err
);

    localparam int DW = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ORR = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;

    // ALU operation codes; the SUB code adds the implicit +1 itself, the
    // SBC code takes the chained no-borrow carry on alu_ci.
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_XOR = 4'b0001;
    localparam logic [3:0] CTL_ORR = 4'b1100;
    localparam logic [3:0] CTL_ADD = 4'b0100;
    localparam logic [3:0] CTL_ADC = 4'b0101;
    localparam logic [3:0] CTL_SUB = 4'b0010;
    localparam logic [3:0] CTL_SBC = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [2:0]        op_q;
    logic [DW-1:0]     a_q;
    logic [DW-1:0]     b_q;
    logic [WIDTH-1:0]  lo_q;
    logic              carry_q;
    logic              lo_z_q;

    logic              accept;
    logic              req_legal;
    logic              op_arith;

    function automatic logic [3:0] ctl_lo(input logic [2:0] op);
        case (op)
            OP_ADD:         ctl_lo = CTL_ADD;
            OP_SUB, OP_CMP: ctl_lo = CTL_SUB;
            OP_AND:         ctl_lo = CTL_AND;
            OP_XOR:         ctl_lo = CTL_XOR;
            OP_ORR:         ctl_lo = CTL_ORR;
            default:        ctl_lo = CTL_AND;
        endcase
    endfunction

    function automatic logic [3:0] ctl_hi(input logic [2:0] op);
        case (op)
            OP_ADD:         ctl_hi = CTL_ADC;
            OP_SUB, OP_CMP: ctl_hi = CTL_SBC;
            default:        ctl_hi = ctl_lo(op);
        endcase
    endfunction

    assign req_legal = (req_op <= OP_CMP);
    assign accept    = (state == S_IDLE) && req_valid;
    assign op_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_CMP);

    // State register; reset wins over every handshake input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and ALU drive (parked at zero outside LO/HI).
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_control = CTL_AND;
        alu_ci      = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_legal ? S_LO : S_RESP;
                end
            end
            S_LO: begin
                alu_control = ctl_lo(op_q);
                alu_a       = a_q[WIDTH-1:0];
                alu_b       = b_q[WIDTH-1:0];
                state_nxt   = S_HI;
            end
            S_HI: begin
                alu_control = ctl_hi(op_q);
                alu_ci      = op_arith & carry_q;
                alu_a       = a_q[DW-1:WIDTH];
                alu_b       = b_q[DW-1:WIDTH];
                state_nxt   = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
        end
    end

    // Latch the low-word result, carry and zero at the end of LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q    <= '0;
            carry_q <= 1'b0;
            lo_z_q  <= 1'b0;
        end else if (state == S_LO) begin
            lo_q    <= alu_out;
            carry_q <= alu_co;
            lo_z_q  <= alu_z;
        end
    end

    // Response registers: error response straight from IDLE, full result at end of HI.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_c      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept && !req_legal) begin
            rsp_result <= '0;
            rsp_c      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_err    <= 1'b1;
        end else if (state == S_HI) begin
            // CMP keeps the flags of A-B but discards the difference.
            rsp_result <= (op_q == OP_CMP) ? '0 : {alu_out, lo_q};
            rsp_c      <= op_arith & alu_co;
            rsp_v      <= op_arith & alu_ovf;
            rsp_z      <= lo_z_q & alu_z;
            rsp_n      <= alu_n;
            rsp_err    <= 1'b0;
        end
    end

endmodule
